// File: rtl/iq_sweep_ctrl_pkg.sv
// Shared types for the IQ sweep controller and its I/Q accumulator.
package iq_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      ACQ,
      OUT
   } sweep_state_t;

   // Exact width needed to sum 2^acc_log2 signed samples without overflow.
   function automatic int unsigned acc_width(input int unsigned data_width,
                                             input int unsigned acc_log2);
      return data_width + acc_log2;
   endfunction

endpackage

// File: rtl/iq_sweep_ctrl_if.sv
// Control, demodulator and result signals of the IQ sweep controller.
interface iq_sweep_ctrl_if #(
   parameter int unsigned PHASE_WIDTH = 32,
   parameter int unsigned DATA_WIDTH  = 12,
   parameter int unsigned CH_WIDTH    = 8,
   parameter int unsigned ACC_LOG2    = 4
);
   import iq_ctrl_pkg::*;

   localparam int unsigned AW = acc_width(DATA_WIDTH, ACC_LOG2);

   logic                          start;
   logic                          abort;
   logic                          continuous;
   logic        [PHASE_WIDTH-1:0] start_word;
   logic        [PHASE_WIDTH-1:0] step_word;
   logic        [CH_WIDTH-1:0]    num_ch;
   logic        [PHASE_WIDTH-1:0] fre_word;
   logic                          dec_ce;
   logic signed [DATA_WIDTH-1:0]  i_in;
   logic signed [DATA_WIDTH-1:0]  q_in;
   logic                          out_valid;
   logic                          out_ready;
   logic        [CH_WIDTH-1:0]    out_ch;
   logic signed [AW-1:0]          out_i_sum;
   logic signed [AW-1:0]          out_q_sum;
   logic                          busy;
   logic                          sweep_done;

   modport master (
      output start, abort, continuous, start_word, step_word, num_ch,
             dec_ce, i_in, q_in, out_ready,
      input  fre_word, out_valid, out_ch, out_i_sum, out_q_sum, busy, sweep_done
   );

   modport slave (
      input  start, abort, continuous, start_word, step_word, num_ch,
             dec_ce, i_in, q_in, out_ready,
      output fre_word, out_valid, out_ch, out_i_sum, out_q_sum, busy, sweep_done
   );

endinterface

// File: rtl/iq_sweep_ctrl_acc.sv
// Dual signed I/Q accumulator over 2^ACC_LOG2 samples; o_*_next is the sum
// including the sample currently presented, o_term flags the final sample.
module iq_pair_acc
   import iq_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned ACC_LOG2   = 4,
   localparam int unsigned AW        = acc_width(DATA_WIDTH, ACC_LOG2)
) (
   input  logic                         i_clk,
   input  logic                         i_clr,
   input  logic                         i_en,
   input  logic signed [DATA_WIDTH-1:0] i_i,
   input  logic signed [DATA_WIDTH-1:0] i_q,
   output logic signed [AW-1:0]         o_i_next,
   output logic signed [AW-1:0]         o_q_next,
   output logic                         o_term
);

   logic signed [AW-1:0]       r_i_acc;
   logic signed [AW-1:0]       r_q_acc;
   logic        [ACC_LOG2-1:0] r_cnt;
   logic signed [AW-1:0]       w_i_ext;
   logic signed [AW-1:0]       w_q_ext;

   assign w_i_ext  = {{ACC_LOG2{i_i[DATA_WIDTH-1]}}, i_i};
   assign w_q_ext  = {{ACC_LOG2{i_q[DATA_WIDTH-1]}}, i_q};
   assign o_i_next = r_i_acc + w_i_ext;
   assign o_q_next = r_q_acc + w_q_ext;
   assign o_term   = i_en && (&r_cnt);

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_i_acc <= '0;
         r_q_acc <= '0;
         r_cnt   <= '0;
      end else if (i_en) begin
         r_i_acc <= o_i_next;
         r_q_acc <= o_q_next;
         r_cnt   <= r_cnt + ACC_LOG2'(1);
      end
   end

endmodule

// File: rtl/iq_sweep_ctrl.sv
// Steps the demodulator LO word across equally spaced channels, discarding
// settling samples after each retune and reporting one I/Q sum per channel.
module iq_sweep_ctrl
   import iq_ctrl_pkg::*;
#(
   parameter int unsigned PHASE_WIDTH = 32,
   parameter int unsigned DATA_WIDTH  = 12,
   parameter int unsigned CH_WIDTH    = 8,
   parameter int unsigned SETTLE_LEN  = 4,
   parameter int unsigned ACC_LOG2    = 4
) (
   input  logic           clk_in,
   input  logic           RST,
   iq_sweep_ctrl_if.slave bus
);

   localparam int unsigned   AW          = acc_width(DATA_WIDTH, ACC_LOG2);
   localparam int unsigned   SW          = (SETTLE_LEN > 1) ? $clog2(SETTLE_LEN) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_LEN - 1);

   sweep_state_t            r_state;
   logic [PHASE_WIDTH-1:0]  r_fre_word;
   logic [PHASE_WIDTH-1:0]  r_start_word;
   logic [PHASE_WIDTH-1:0]  r_step_word;
   logic [CH_WIDTH-1:0]     r_num_ch;
   logic [CH_WIDTH-1:0]     r_ch_idx;
   logic [CH_WIDTH-1:0]     r_out_ch;
   logic                    r_cont;
   logic                    r_out_valid;
   logic                    r_sweep_done;
   logic [SW-1:0]           r_settle_cnt;
   logic signed [AW-1:0]    r_out_i;
   logic signed [AW-1:0]    r_out_q;

   logic                    w_settle_done;
   logic                    w_acc_clr;
   logic                    w_acc_en;
   logic                    w_acc_term;
   logic                    w_handshake;
   logic                    w_last_ch;
   logic signed [AW-1:0]    w_i_next;
   logic signed [AW-1:0]    w_q_next;

   assign w_settle_done = (r_state == SETTLE) && bus.dec_ce && (r_settle_cnt == SETTLE_LAST);
   assign w_acc_clr     = RST || bus.abort || w_settle_done;
   assign w_acc_en      = (r_state == ACQ) && bus.dec_ce;
   assign w_handshake   = (r_state == OUT) && r_out_valid && bus.out_ready;
   assign w_last_ch     = (r_ch_idx == (r_num_ch - CH_WIDTH'(1)));

   iq_pair_acc #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_LOG2   (ACC_LOG2)
   ) u_acc (
      .i_clk    (clk_in),
      .i_clr    (w_acc_clr),
      .i_en     (w_acc_en),
      .i_i      (bus.i_in),
      .i_q      (bus.q_in),
      .o_i_next (w_i_next),
      .o_q_next (w_q_next),
      .o_term   (w_acc_term)
   );

   always_ff @(posedge clk_in) begin
      r_sweep_done <= 1'b0;
      if (RST) begin
         r_state      <= IDLE;
         r_fre_word   <= '0;
         r_start_word <= '0;
         r_step_word  <= '0;
         r_num_ch     <= '0;
         r_ch_idx     <= '0;
         r_out_ch     <= '0;
         r_cont       <= 1'b0;
         r_out_valid  <= 1'b0;
         r_settle_cnt <= '0;
         r_out_i      <= '0;
         r_out_q      <= '0;
      end else if (bus.abort) begin
         // Abort keeps the last LO word so the mixer is not retuned behind our back.
         r_state      <= IDLE;
         r_out_valid  <= 1'b0;
         r_ch_idx     <= '0;
         r_settle_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start && (bus.num_ch != '0)) begin
                  r_num_ch     <= bus.num_ch;
                  r_start_word <= bus.start_word;
                  r_step_word  <= bus.step_word;
                  r_cont       <= bus.continuous;
                  r_fre_word   <= bus.start_word;
                  r_ch_idx     <= '0;
                  r_settle_cnt <= '0;
                  r_state      <= SETTLE;
               end
            end
            SETTLE: begin
               if (bus.dec_ce) begin
                  r_settle_cnt <= r_settle_cnt + SW'(1);
                  if (w_settle_done) r_state <= ACQ;
               end
            end
            ACQ: begin
               if (w_acc_term) begin
                  r_out_i     <= w_i_next;
                  r_out_q     <= w_q_next;
                  r_out_ch    <= r_ch_idx;
                  r_out_valid <= 1'b1;
                  r_state     <= OUT;
               end
            end
            OUT: begin
               if (w_handshake) begin
                  r_out_valid  <= 1'b0;
                  r_settle_cnt <= '0;
                  if (w_last_ch) begin
                     r_sweep_done <= 1'b1;
                     if (r_cont) begin
                        r_fre_word <= r_start_word;
                        r_ch_idx   <= '0;
                        r_state    <= SETTLE;
                     end else begin
                        r_state <= IDLE;
                     end
                  end else begin
                     r_ch_idx   <= r_ch_idx + CH_WIDTH'(1);
                     r_fre_word <= r_fre_word + r_step_word;
                     r_state    <= SETTLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.fre_word   = r_fre_word;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_ch     = r_out_ch;
   assign bus.out_i_sum  = r_out_i;
   assign bus.out_q_sum  = r_out_q;
   assign bus.busy       = (r_state != IDLE);
   assign bus.sweep_done = r_sweep_done;

endmodule

// File: tb/tb_iq_sweep_ctrl.sv
// Self-checking bench for iq_sweep_ctrl with a transaction-level channel model.
module tb_iq_sweep_ctrl;

   logic clk_in = 1'b0;
   logic RST    = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;

   iq_sweep_ctrl_if #(
      .PHASE_WIDTH (32),
      .DATA_WIDTH  (12),
      .CH_WIDTH    (8),
      .ACC_LOG2    (2)
   ) bus ();

   iq_sweep_ctrl #(
      .PHASE_WIDTH (32),
      .DATA_WIDTH  (12),
      .CH_WIDTH    (8),
      .SETTLE_LEN  (4),
      .ACC_LOG2    (2)
   ) dut (
      .clk_in (clk_in),
      .RST    (RST),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic pulse_start(input logic [31:0] sw, input logic [31:0] st,
                              input logic [7:0] nch, input logic cont);
      bus.start      = 1'b1;
      bus.start_word = sw;
      bus.step_word  = st;
      bus.num_ch     = nch;
      bus.continuous = cont;
      tick();
      bus.start      = 1'b0;
      bus.start_word = $urandom;
      bus.step_word  = $urandom;
      bus.num_ch     = 8'($urandom);
      bus.continuous = 1'($urandom);
   endtask

   task automatic strobe(input int vi, input int vq, input int gap);
      bus.dec_ce = 1'b1;
      bus.i_in   = 12'(vi);
      bus.q_in   = 12'(vq);
      tick();
      bus.dec_ce = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (bus.out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Channel k consumes strobes 8k..8k+7; only the last four are summed.
   task automatic run_sweep(input string tag, input logic [31:0] sw, input logic [31:0] st,
                            input int nch, input int mode);
      int isamp[$];
      int qsamp[$];
      int got, dones, ns, ei, eq, vi, vq;
      logic [11:0] r12;
      logic [31:0] efw;
      got = 0; dones = 0; ns = 0;
      bus.out_ready = 1'b1;
      pulse_start(sw, st, 8'(nch), 1'b0);
      n_total++;
      if (bus.fre_word !== sw) $display("FAIL %s_first_word: got %h want %h", tag, bus.fre_word, sw);
      else n_pass++;
      for (int c = 0; c < nch * 80 + 40; c++) begin
         if ((c % 10 == 0) && (ns < nch * 8)) begin
            case (mode)
               0: begin vi = 5; vq = -3; end
               1: begin
                  r12 = 12'($urandom); vi = int'($signed(r12));
                  r12 = 12'($urandom); vq = int'($signed(r12));
               end
               default: begin
                  vi = ((ns % 8) < 4) ? 100 : 1;
                  vq = ((ns % 8) < 4) ? -50 : -2;
               end
            endcase
            isamp.push_back(vi);
            qsamp.push_back(vq);
            bus.dec_ce = 1'b1;
            bus.i_in   = 12'(vi);
            bus.q_in   = 12'(vq);
            ns++;
         end else begin
            bus.dec_ce = 1'b0;
         end
         tick();
         if (bus.out_valid === 1'b1) begin
            n_total++;
            if (got >= nch) begin
               $display("FAIL %s_extra_result: got result %0d want only %0d", tag, got, nch);
            end else begin
               ei = 0; eq = 0;
               for (int k = 4; k < 8; k++) begin
                  ei += isamp[got * 8 + k];
                  eq += qsamp[got * 8 + k];
               end
               efw = sw + st * 32'(got);
               if (bus.out_ch !== 8'(got) || bus.out_i_sum !== 14'(ei) ||
                   bus.out_q_sum !== 14'(eq) || bus.fre_word !== efw)
                  $display("FAIL %s_result%0d: got ch=%0d i=%0d q=%0d fw=%h want ch=%0d i=%0d q=%0d fw=%h",
                           tag, got, bus.out_ch, bus.out_i_sum, bus.out_q_sum, bus.fre_word,
                           got, ei, eq, efw);
               else n_pass++;
            end
            got++;
         end
         if (bus.sweep_done === 1'b1) dones++;
      end
      bus.dec_ce = 1'b0;
      n_total++;
      if (got !== nch || dones !== 1 || bus.busy !== 1'b0)
         $display("FAIL %s_end: got results=%0d dones=%0d busy=%b want %0d 1 0", tag, got, dones, bus.busy, nch);
      else n_pass++;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) tick();
      RST = 1'b0;
      n_total++;
      if (bus.fre_word !== '0 || bus.out_valid !== 1'b0 || bus.out_ch !== '0 || bus.out_i_sum !== '0 ||
          bus.out_q_sum !== '0 || bus.busy !== 1'b0 || bus.sweep_done !== 1'b0)
         $display("FAIL reset_outputs: got fw=%h v=%b ch=%0d i=%0d q=%0d busy=%b done=%b want all 0",
                  bus.fre_word, bus.out_valid, bus.out_ch, bus.out_i_sum, bus.out_q_sum, bus.busy, bus.sweep_done);
      else n_pass++;
   endtask

   task automatic test_reset_mid_acq();
      bit seen;
      bus.out_ready = 1'b1;
      pulse_start(32'h4000_0000, 32'h0000_0100, 8'd3, 1'b0);
      for (int s = 0; s < 6; s++) strobe(7, 7, 2);
      RST = 1'b1;
      repeat (3) tick();
      RST = 1'b0;
      n_total++;
      if (bus.fre_word !== '0 || bus.out_valid !== 1'b0 || bus.out_ch !== '0 || bus.out_i_sum !== '0 ||
          bus.out_q_sum !== '0 || bus.busy !== 1'b0 || bus.sweep_done !== 1'b0)
         $display("FAIL reset_mid_acq: got fw=%h v=%b ch=%0d i=%0d q=%0d busy=%b done=%b want all 0",
                  bus.fre_word, bus.out_valid, bus.out_ch, bus.out_i_sum, bus.out_q_sum, bus.busy, bus.sweep_done);
      else n_pass++;
      seen = 1'b0;
      for (int s = 0; s < 10; s++) begin
         strobe(3, 3, 2);
         if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
      end
      n_total++;
      if (seen) $display("FAIL reset_idle: got activity after reset want none");
      else n_pass++;
   endtask

   task automatic test_single_sweep();
      run_sweep("single", 32'h1000_0000, 32'h0100_0000, 3, 0);
   endtask

   task automatic test_settle_discard();
      run_sweep("settle", $urandom, $urandom, 1, 2);
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++)
         run_sweep("random", $urandom, $urandom, int'($urandom_range(1, 4)), 1);
   endtask

   task automatic test_backpressure();
      bit ok, held;
      bus.out_ready = 1'b0;
      pulse_start(32'h2000_0000, 32'h0000_1000, 8'd2, 1'b0);
      for (int s = 0; s < 8; s++) strobe(5, -3, 2);
      wait_valid(ok);
      n_total++;
      if (!ok) $display("FAIL bp_valid_timeout: got no out_valid want out_valid");
      else n_pass++;
      held = 1'b1;
      for (int c = 0; c < 50; c++) begin
         bus.dec_ce = ((c % 3) == 0);
         bus.i_in   = 12'($urandom);
         bus.q_in   = 12'($urandom);
         if (c == 10) begin
            bus.start = 1'b1; bus.start_word = 32'h7777_0000; bus.num_ch = 8'd5;
         end
         tick();
         bus.start  = 1'b0;
         bus.dec_ce = 1'b0;
         if (bus.out_valid !== 1'b1 || bus.out_i_sum !== 14'd20 || bus.out_q_sum !== -14'sd12 ||
             bus.fre_word !== 32'h2000_0000 || bus.out_ch !== 8'd0)
            held = 1'b0;
      end
      n_total++;
      if (!held) $display("FAIL bp_held: got v=%b i=%0d q=%0d fw=%h want 1 20 -12 20000000",
                          bus.out_valid, bus.out_i_sum, bus.out_q_sum, bus.fre_word);
      else n_pass++;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      n_total++;
      if (bus.out_valid !== 1'b0 || bus.fre_word !== 32'h2000_1000 || bus.busy !== 1'b1)
         $display("FAIL bp_resume: got v=%b fw=%h busy=%b want 0 20001000 1", bus.out_valid, bus.fre_word, bus.busy);
      else n_pass++;
      for (int s = 0; s < 8; s++) strobe(1, 2, 2);
      wait_valid(ok);
      n_total++;
      if (!ok || bus.out_ch !== 8'd1 || bus.out_i_sum !== 14'd4 || bus.out_q_sum !== 14'd8)
         $display("FAIL bp_second: got ok=%b ch=%0d i=%0d q=%0d want 1 1 4 8", ok, bus.out_ch, bus.out_i_sum, bus.out_q_sum);
      else n_pass++;
      bus.out_ready = 1'b1;
      tick();
      n_total++;
      if (bus.sweep_done !== 1'b1 || bus.busy !== 1'b0)
         $display("FAIL bp_done: got done=%b busy=%b want 1 0", bus.sweep_done, bus.busy);
      else n_pass++;
   endtask

   task automatic test_wrap_continuous();
      logic [31:0] exp_seq [4];
      int got, dones, ns;
      exp_seq = '{32'hFF00_0000, 32'h0000_0000, 32'hFF00_0000, 32'h0000_0000};
      got = 0; dones = 0; ns = 0;
      bus.out_ready = 1'b1;
      pulse_start(32'hFF00_0000, 32'h0100_0000, 8'd2, 1'b1);
      for (int c = 0; c < 340; c++) begin
         bus.dec_ce = ((c % 10) == 0) && (ns < 32);
         if (bus.dec_ce) ns++;
         tick();
         bus.dec_ce = 1'b0;
         if (bus.out_valid === 1'b1) begin
            n_total++;
            if (got >= 4 || bus.fre_word !== exp_seq[got])
               $display("FAIL wrap_word%0d: got %h want %h", got, bus.fre_word, (got < 4) ? exp_seq[got] : 32'h0);
            else n_pass++;
            got++;
         end
         if (bus.sweep_done === 1'b1) begin
            dones++;
            n_total++;
            if (bus.fre_word !== 32'hFF00_0000 || bus.busy !== 1'b1)
               $display("FAIL wrap_reload: got fw=%h busy=%b want ff000000 1", bus.fre_word, bus.busy);
            else n_pass++;
         end
      end
      n_total++;
      if (got !== 4 || dones !== 2)
         $display("FAIL wrap_counts: got results=%0d dones=%0d want 4 2", got, dones);
      else n_pass++;
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      n_total++;
      if (bus.busy !== 1'b0 || bus.fre_word !== 32'hFF00_0000 || bus.sweep_done !== 1'b0)
         $display("FAIL wrap_abort: got busy=%b fw=%h done=%b want 0 ff000000 0", bus.busy, bus.fre_word, bus.sweep_done);
      else n_pass++;
   endtask

   task automatic test_abort_edge();
      bit ok, quiet;
      bus.out_ready = 1'b0;
      pulse_start(32'h3000_0000, 32'h0000_0010, 8'd1, 1'b0);
      for (int s = 0; s < 8; s++) strobe(2, 2, 2);
      wait_valid(ok);
      bus.abort     = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.abort = 1'b0;
      quiet = (bus.sweep_done === 1'b0);
      tick();
      quiet = quiet && (bus.sweep_done === 1'b0);
      n_total++;
      if (!ok || !quiet || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.fre_word !== 32'h3000_0000)
         $display("FAIL abort_handshake: got ok=%b quiet=%b busy=%b v=%b fw=%h want 1 1 0 0 30000000",
                  ok, quiet, bus.busy, bus.out_valid, bus.fre_word);
      else n_pass++;
      bus.start = 1'b1; bus.abort = 1'b1; bus.num_ch = 8'd2; bus.start_word = 32'h5555_0000;
      tick();
      bus.start = 1'b0; bus.abort = 1'b0;
      n_total++;
      if (bus.busy !== 1'b0 || bus.fre_word !== 32'h3000_0000)
         $display("FAIL start_abort_idle: got busy=%b fw=%h want 0 30000000", bus.busy, bus.fre_word);
      else n_pass++;
      pulse_start(32'h6666_0000, 32'h1, 8'd0, 1'b0);
      repeat (3) tick();
      n_total++;
      if (bus.busy !== 1'b0 || bus.fre_word !== 32'h3000_0000)
         $display("FAIL zero_ch_start: got busy=%b fw=%h want 0 30000000", bus.busy, bus.fre_word);
      else n_pass++;
   endtask

   initial begin
      bus.start = 1'b0; bus.abort = 1'b0; bus.continuous = 1'b0;
      bus.start_word = '0; bus.step_word = '0; bus.num_ch = '0;
      bus.dec_ce = 1'b0; bus.i_in = '0; bus.q_in = '0; bus.out_ready = 1'b0;
      test_reset();
      test_single_sweep();
      test_backpressure();
      test_wrap_continuous();
      test_settle_discard();
      test_abort_edge();
      test_random();
      test_reset_mid_acq();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got simulation still running want finished");
      $fatal(1, "watchdog expired");
   end

endmodule
